// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-master Avalon-MM RAM arbiter.
// Holds FSM state/owner encodings and the default abort read data.
package avalon_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef enum logic {
    OWN_M0,
    OWN_M1
  } arb_owner_t;

  localparam logic [31:0] ABORT_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Stall watchdog: counts granted cycles with the slave stalling.
// Ports: clk, reset_n, clear (hold count at 0), stall, expired.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expiry is the Nth stalled cycle itself, so the abort
  // completes in that same cycle.
  assign expired = stall && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stall && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter, round-robin, with watchdog.
// Ports: m0_*/m1_* master side, s_* RAM side, timeout_err sticky flag.
module avalon_mem_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ABORT_DATA     = ABORT_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic        timeout_err
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  arb_owner_t last_q, last_d;
  logic       terr_q, terr_d;

  logic        req0;
  logic        req1;
  logic        own_req;
  logic        granted;
  logic        stall;
  logic        expired;
  logic        done;
  logic [31:0] cpl_data;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign own_req = (owner_q == OWN_M0) ? req0 : req1;
  assign granted = (state_q == GRANT);
  assign stall   = granted & s_waitrequest;

  // done depends only on registered state and the slave,
  // never on master inputs.
  assign done     = granted & (~s_waitrequest | expired);
  assign cpl_data = expired ? ABORT_DATA : s_readdata;

  assign timeout_err = terr_q;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == IDLE),
    .stall  (stall),
    .expired(expired)
  );

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    if (granted) begin
      unique case (owner_q)
        OWN_M0: begin
          s_address      = m0_address;
          s_read         = m0_read & ~m0_write;
          s_write        = m0_write;
          s_writedata    = m0_writedata;
          s_byteenable   = m0_byteenable;
          m0_waitrequest = ~done;
          m0_readdata    = done ? cpl_data : '0;
        end
        OWN_M1: begin
          s_address      = m1_address;
          s_read         = m1_read & ~m1_write;
          s_write        = m1_write;
          s_writedata    = m1_writedata;
          s_byteenable   = m1_byteenable;
          m1_waitrequest = ~done;
          m1_readdata    = done ? cpl_data : '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = GRANT;
          if (req0 && req1) begin
            owner_d = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
          end else begin
            owner_d = req0 ? OWN_M0 : OWN_M1;
          end
        end
      end
      GRANT: begin
        // A withdrawn request is dropped without
        // touching the fairness pointer.
        if (!own_req) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          last_d  = owner_q;
          if (expired) begin
            terr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_M0;
      last_q  <= OWN_M1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Randomised and directed bench for avalon_mem_arbiter.
// Transaction-level model predicts every output each cycle.
module tb_avalon_mem_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] ABRT = 32'hDEADBEEF;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          gap;
    int          hold;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] maddr[2];
  logic [31:0] mwd[2];
  logic [31:0] mrdat[2];
  logic        mrd[2];
  logic        mwr[2];
  logic        mwait[2];
  logic [3:0]  mbe[2];

  logic [31:0] s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_read;
  logic        s_write;
  logic        s_waitrequest;
  logic [3:0]  s_byteenable;
  logic        timeout_err;

  logic [31:0] ram[32];
  assign s_readdata = ram[s_address[6:2]];

  avalon_mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ABORT_DATA    (ABRT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .m0_address    (maddr[0]),
    .m0_read       (mrd[0]),
    .m0_write      (mwr[0]),
    .m0_writedata  (mwd[0]),
    .m0_byteenable (mbe[0]),
    .m0_readdata   (mrdat[0]),
    .m0_waitrequest(mwait[0]),
    .m1_address    (maddr[1]),
    .m1_read       (mrd[1]),
    .m1_write      (mwr[1]),
    .m1_writedata  (mwd[1]),
    .m1_byteenable (mbe[1]),
    .m1_readdata   (mrdat[1]),
    .m1_waitrequest(mwait[1]),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_byteenable  (s_byteenable),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .timeout_err   (timeout_err)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  bit          busy;
  int          own;
  int          last;
  int          wcnt;
  bit          terr;
  logic [31:0] mmem[32];

  req_t q0[$];
  req_t q1[$];
  req_t cur[2];
  bit   act[2];
  int   gapc[2];
  int   held[2];
  int   start_cyc[2];
  bit   done_now[2];

  int  wait_pct;
  int  stall_left;
  bit  force_stall;

  int          log_cyc[$];
  int          log_own[$];
  int          log_lat[$];
  logic [31:0] log_data[$];

  task automatic cmp(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic req_t mk(bit rd, bit wr, logic [31:0] a,
                              logic [31:0] d, logic [3:0] be,
                              int gap, int hold);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.data = d;
    r.be = be; r.gap = gap; r.hold = hold;
    return r;
  endfunction

  task automatic check_cycle();
    logic [31:0] esa, ewd, w;
    logic        esr, esw;
    logic [3:0]  ebe;
    logic        ew[2];
    logic [31:0] erd[2];
    bit          stl, abt, dn;
    bit          rq[2];
    esa = '0; ewd = '0; esr = 1'b0; esw = 1'b0; ebe = '0;
    ew[0] = 1'b1; ew[1] = 1'b1; erd[0] = '0; erd[1] = '0;
    stl = 0; abt = 0; dn = 0;
    done_now[0] = 0; done_now[1] = 0;
    for (int m = 0; m < 2; m++) rq[m] = mrd[m] | mwr[m];
    if (busy) begin
      esa = maddr[own]; ewd = mwd[own]; ebe = mbe[own];
      esw = mwr[own];
      esr = mrd[own] & ~mwr[own];
      stl = s_waitrequest;
      abt = stl && (wcnt + 1 == TO);
      dn  = !stl || abt;
      if (dn) begin
        ew[own]  = 1'b0;
        erd[own] = abt ? ABRT : mmem[esa[6:2]];
      end
    end
    cmp("s_address", s_address, esa);
    cmp("s_read", 32'(s_read), 32'(esr));
    cmp("s_write", 32'(s_write), 32'(esw));
    cmp("s_writedata", s_writedata, ewd);
    cmp("s_byteenable", 32'(s_byteenable), 32'(ebe));
    cmp("m0_waitrequest", 32'(mwait[0]), 32'(ew[0]));
    cmp("m1_waitrequest", 32'(mwait[1]), 32'(ew[1]));
    cmp("m0_readdata", mrdat[0], erd[0]);
    cmp("m1_readdata", mrdat[1], erd[1]);
    cmp("timeout_err", 32'(timeout_err), 32'(terr));
    if (busy) begin
      if (!rq[own]) begin
        busy = 0;
      end else if (dn) begin
        log_cyc.push_back(cyc);
        log_own.push_back(own);
        log_lat.push_back(cyc - start_cyc[own]);
        log_data.push_back(mrdat[own]);
        done_now[own] = 1;
        busy = 0;
        last = own;
        if (abt) terr = 1;
        if (!abt && esw) begin
          w = mmem[esa[6:2]];
          for (int b = 0; b < 4; b++)
            if (ebe[b]) w[8*b +: 8] = ewd[8*b +: 8];
          mmem[esa[6:2]] = w;
        end
      end else begin
        wcnt++;
      end
    end else if (rq[0] || rq[1]) begin
      busy = 1;
      wcnt = 0;
      if (rq[0] && rq[1]) own = 1 - last;
      else own = rq[0] ? 0 : 1;
    end
    if (s_write && !s_waitrequest) begin
      w = ram[s_address[6:2]];
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) w[8*b +: 8] = s_writedata[8*b +: 8];
      ram[s_address[6:2]] = w;
    end
  endtask

  task automatic drive_next();
    for (int m = 0; m < 2; m++) begin
      if (act[m]) begin
        if (done_now[m]) begin
          act[m] = 0;
          gapc[m] = cur[m].gap;
        end else begin
          held[m]++;
          if (cur[m].hold > 0 && held[m] > cur[m].hold) begin
            act[m] = 0;
            gapc[m] = 0;
          end
        end
      end
      if (!act[m]) begin
        if (gapc[m] > 0) begin
          gapc[m]--;
        end else if (m == 0 && q0.size() > 0) begin
          cur[m] = q0.pop_front();
          act[m] = 1; held[m] = 1; start_cyc[m] = cyc;
        end else if (m == 1 && q1.size() > 0) begin
          cur[m] = q1.pop_front();
          act[m] = 1; held[m] = 1; start_cyc[m] = cyc;
        end
      end
      mrd[m]   = act[m] & cur[m].rd;
      mwr[m]   = act[m] & cur[m].wr;
      maddr[m] = act[m] ? cur[m].addr : '0;
      mwd[m]   = act[m] ? cur[m].data : '0;
      mbe[m]   = act[m] ? cur[m].be : '0;
    end
    if (force_stall) begin
      s_waitrequest = 1'b1;
    end else if (stall_left > 0 && busy) begin
      s_waitrequest = 1'b1;
      stall_left--;
    end else begin
      s_waitrequest = ($urandom_range(0, 99) < wait_pct);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive_next();
  endtask

  task automatic run_until_idle(input int max);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !act[0] &&
                 !act[1] && !busy) && k < max);
    n_tests++;
    if (k >= max) begin
      n_fail++;
      $display("FAIL run_budget cyc=%0d got=%0d exp=<%0d", cyc, k, max);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    busy = 0; last = 1; wcnt = 0; terr = 0;
    q0.delete(); q1.delete();
    force_stall = 0; stall_left = 0; wait_pct = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; gapc[m] = 0; held[m] = 0; done_now[m] = 0;
      mrd[m] = 0; mwr[m] = 0; maddr[m] = '0; mwd[m] = '0; mbe[m] = '0;
    end
    s_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic chk_log(input string nm, input int idx, input int o,
                         input int lat, input logic [31:0] d,
                         input bit use_d);
    n_tests++;
    if (idx >= log_own.size()) begin
      n_fail++;
      $display("FAIL %s_missing got=%0d exp=>%0d", nm, log_own.size(), idx);
    end else begin
      n_tests--;
      cmp({nm, "_owner"}, 32'(log_own[idx]), 32'(o));
      if (lat >= 0) cmp({nm, "_lat"}, 32'(log_lat[idx]), 32'(lat));
      if (use_d) cmp({nm, "_data"}, log_data[idx], d);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    ram[idx] = v;
    mmem[idx] = v;
  endtask

  int n0;

  initial begin
    for (int i = 0; i < 32; i++) preload(i, '0);
    do_reset();

    cmp("rst_ctrl",
        32'({s_read, s_write, mwait[0], mwait[1], timeout_err}),
        32'(5'b00110));
    cmp("rst_s_address", s_address, 32'h0);
    cmp("rst_m0_readdata", mrdat[0], 32'h0);
    cmp("rst_m1_readdata", mrdat[1], 32'h0);

    // m0 solo zero-wait read
    preload(1, 32'h240ABFC0);
    n0 = log_own.size();
    q0.push_back(mk(1, 0, 32'h4, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t1", n0, 0, 1, 32'h240ABFC0, 1);

    // simultaneous start, then alternating grants
    do_reset();
    n0 = log_own.size();
    q0.push_back(mk(0, 1, 32'h8, 32'h11111111, 4'hF, 0, 0));
    q0.push_back(mk(1, 0, 32'h8, '0, 4'hF, 0, 0));
    q1.push_back(mk(1, 0, 32'hC, '0, 4'hF, 0, 0));
    q1.push_back(mk(1, 0, 32'h8, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t2a", n0, 0, 1, '0, 0);
    chk_log("t2b", n0 + 1, 1, 3, 32'h0, 1);
    chk_log("t2c", n0 + 2, 0, -1, 32'h11111111, 1);
    chk_log("t2d", n0 + 3, 1, -1, 32'h11111111, 1);

    // stalled partial write then read-back
    do_reset();
    preload(16, 32'hFFFF1234);
    n0 = log_own.size();
    stall_left = 3;
    q1.push_back(mk(0, 1, 32'h40, 32'h00000020, 4'b0011, 1, 0));
    q1.push_back(mk(1, 0, 32'h40, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t3w", n0, 1, 4, '0, 0);
    chk_log("t3r", n0 + 1, 1, 1, 32'hFFFF0020, 1);

    // watchdog abort
    do_reset();
    n0 = log_own.size();
    force_stall = 1;
    q0.push_back(mk(1, 0, 32'h4, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t4", n0, 0, TO, ABRT, 1);
    force_stall = 0;
    repeat (3) step();
    cmp("t4_terr_sticky", 32'(timeout_err), 32'h1);
    do_reset();
    cmp("t4_terr_cleared", 32'(timeout_err), 32'h0);

    // async reset mid-transfer
    force_stall = 1;
    q0.push_back(mk(1, 0, 32'h4, '0, 4'hF, 0, 0));
    repeat (3) step();
    cmp("t5_strobe_before", 32'(s_read), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    cmp("t5_async_ctrl",
        32'({s_read, s_write, mwait[0], mwait[1]}), 32'(4'b0011));
    cmp("t5_async_addr", s_address, 32'h0);
    do_reset();
    n0 = log_own.size();
    q0.push_back(mk(1, 0, 32'h4, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t5", n0, 0, 1, 32'h240ABFC0, 1);

    // withdrawn request leaves fairness pointer alone
    do_reset();
    q0.push_back(mk(1, 0, 32'h4, '0, 4'hF, 0, 0));
    run_until_idle(50);
    force_stall = 1;
    n0 = log_own.size();
    q1.push_back(mk(0, 1, 32'h20, 32'h55AA55AA, 4'hF, 0, 2));
    run_until_idle(50);
    cmp("t6_no_completion", 32'(log_own.size()), 32'(n0));
    force_stall = 0;
    q0.push_back(mk(1, 0, 32'h8, '0, 4'hF, 0, 0));
    q1.push_back(mk(1, 0, 32'h8, '0, 4'hF, 0, 0));
    run_until_idle(50);
    chk_log("t6_tie", n0, 1, 1, '0, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    wait_pct = 25;
    n0 = log_own.size();
    for (int i = 0; i < 150; i++) begin
      q0.push_back(mk(bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)),
                      {25'd0, 5'($urandom_range(0, 31)), 2'b00},
                      $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2), 0));
      q1.push_back(mk(bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)),
                      {25'd0, 5'($urandom_range(0, 31)), 2'b00},
                      $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2), 0));
    end
    for (int i = 0; i < 150; i++) begin
      if (!q0[i].rd && !q0[i].wr) q0[i].rd = 1;
      if (!q1[i].rd && !q1[i].wr) q1[i].wr = 1;
    end
    run_until_idle(20000);
    cmp("rand_completions", 32'(log_own.size() - n0), 32'd300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
# avalon_mem_arbiter

Two-master, one-slave Avalon-MM arbiter that shares the single-port RAM between the CPU bus master (port m0) and a secondary master such as a program loader or debug port (port m1). It sits between `top_level_cpu` and `RAM`. It grants one transfer at a time with round-robin fairness and forwards the granted master's signals to the RAM. A watchdog aborts any transfer the RAM stalls indefinitely.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of consecutive granted cycles with `s_waitrequest` high before the transfer is aborted (1..65535).
- ABORT_DATA, 32'hDEADBEEF: `readdata` returned on an aborted read.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_address / m1_address  in  32  master byte address.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_readdata / m1_readdata  out  32  read data; valid in the cycle that master's waitrequest is low after a read.
- m0_waitrequest / m1_waitrequest  out  1  stall to the master.
- s_address, s_read, s_write, s_writedata, s_byteenable  out  32/1/1/32/4  to RAM.
- s_readdata  in  32  from RAM.
- s_waitrequest  in  1  from RAM.
- timeout_err  out  1  sticky; set on any watchdog abort, cleared only by reset.

## Operation
- A master requests when `read | write` is high. It must hold all of its signals stable while its waitrequest is high.
- If both read and write are high, the request is a write; the read is ignored.
- FSM states:
  - IDLE: slave outputs inactive. If any master requests, register `owner` and go to GRANT. With both requesting, pick the master not in `last_owner`.
  - GRANT: slave outputs mux `owner`'s signals. On `s_waitrequest==0`, complete: drop `owner`'s waitrequest, route `s_readdata` to `owner`'s readdata, set `last_owner=owner`, go to IDLE. If `owner` deasserts its request while in GRANT (illegal), go to IDLE with no completion and no `last_owner` update.
  - GRANT on watchdog expiry: complete to the master with readdata=ABORT_DATA (reads) and the write discarded. Set `timeout_err`, update `last_owner`, go to IDLE.
- Watchdog counter: cleared on entry to GRANT; increments each GRANT cycle with `s_waitrequest` high; expiry when count reaches TIMEOUT_CYCLES-1 with `s_waitrequest` still high. The counter width fits TIMEOUT_CYCLES.
- Non-owner waitrequest is always high. Non-owner readdata is 0. Owner readdata is 0 except in the completion cycle.
- Reset values:
  - state=IDLE, last_owner=m1 (so m0 wins the first tie), counter=0, timeout_err=0.
  - All s_* outputs 0; m*_waitrequest=1; m*_readdata=0.

## Timing
- Request first seen in IDLE at cycle N: slave strobe asserted at N+1. Completion at N+1 at the earliest, when RAM waitrequest is low that cycle.
- Minimum two cycles per transfer, including back-to-back transfers from one master; IDLE always intervenes.
- Slave outputs and master waitrequest/readdata are combinational from the registered state/owner plus `s_waitrequest`/`s_readdata`. There are no comb paths from master inputs to m*_waitrequest.
- A request that appears in the same cycle another transfer completes is seen in the following IDLE cycle.
- Asynchronous reset mid-GRANT: outputs go to their reset values immediately, and the in-flight transfer is dropped.
- Watchdog abort fires exactly TIMEOUT_CYCLES GRANT cycles after the strobe is first asserted.

## Structure
- Package `avalon_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, GRANT}
  - enum `arb_owner_t` {OWN_M0, OWN_M1}
  - localparam for the default ABORT_DATA.
- One sub-module, `arb_watchdog` (clk, reset_n, clear, stall, expired; parameter TIMEOUT_CYCLES), instantiated once.
- Top module holds the FSM, round-robin pointer and muxes.

## Test plan
- m0 reads 0x04 alone, RAM zero-wait: s_read high at N+1, m0_waitrequest low at N+1, m0_readdata=RAM[0x04] (e.g. 32'h240ABFC0), m1_waitrequest stays 1.
- m0 write and m1 read asserted in the same cycle from reset: m0 is served first, m1 served two cycles later; each master then holds a second request and grants alternate m0, m1, m0, m1.
- RAM holds waitrequest high for 3 cycles on an m1 write of 32'h00000020 to 0x40 with byteenable=4'b0011: s_* stable for 4 cycles, m1 completes on cycle 4, and a read-back returns the low half only.
- TIMEOUT_CYCLES=8, RAM never drops waitrequest on an m0 read: m0 completes exactly 8 GRANT cycles later with readdata 32'hDEADBEEF; timeout_err=1 and stays 1 until reset_n low.
- reset_n pulsed low mid-GRANT: all outputs return to reset values asynchronously, and the next m0 request after release completes normally.
- m1 drops its request while in GRANT: the FSM returns to IDLE with no completion pulse and last_owner unchanged, so a subsequent tie is still resolved as before.
